tl_source_shrinker: RTL and testbench



---
 rtl/tl_source_shrinker.sv | 200 ++++++++++++++++++++
 tb/tb_tl_source_shrinker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_source_shrinker.sv
// Compacts a wide host TL source-ID space onto a few device source IDs using a
// live allocation table; D responses are mapped back through the table.
module tl_source_shrinker #(
  parameter int HostSourceWidth   = 8,
  parameter int DeviceSourceWidth = 2,
  parameter int SinkWidth         = 1,
  parameter int AddrWidth         = 56,
  parameter int DataWidth         = 64,
  parameter int MaxSize           = 6,
  parameter int SizeWidth         = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,

  input  logic                         host_a_valid,
  output logic                         host_a_ready,
  input  logic [2:0]                   host_a_opcode,
  input  logic [2:0]                   host_a_param,
  input  logic [SizeWidth-1:0]         host_a_size,
  input  logic [HostSourceWidth-1:0]   host_a_source,
  input  logic [AddrWidth-1:0]         host_a_address,
  input  logic [DataWidth/8-1:0]       host_a_mask,
  input  logic [DataWidth-1:0]         host_a_data,
  input  logic                         host_a_corrupt,

  output logic                         device_a_valid,
  input  logic                         device_a_ready,
  output logic [2:0]                   device_a_opcode,
  output logic [2:0]                   device_a_param,
  output logic [SizeWidth-1:0]         device_a_size,
  output logic [DeviceSourceWidth-1:0] device_a_source,
  output logic [AddrWidth-1:0]         device_a_address,
  output logic [DataWidth/8-1:0]       device_a_mask,
  output logic [DataWidth-1:0]         device_a_data,
  output logic                         device_a_corrupt,

  output logic                         host_b_valid,
  input  logic                         host_b_ready,
  input  logic                         device_b_valid,
  output logic                         device_b_ready,

  input  logic                         host_c_valid,
  output logic                         host_c_ready,
  output logic                         device_c_valid,
  input  logic                         device_c_ready,

  input  logic                         device_d_valid,
  output logic                         device_d_ready,
  input  logic [2:0]                   device_d_opcode,
  input  logic [1:0]                   device_d_param,
  input  logic [SizeWidth-1:0]         device_d_size,
  input  logic [DeviceSourceWidth-1:0] device_d_source,
  input  logic [SinkWidth-1:0]         device_d_sink,
  input  logic                         device_d_denied,
  input  logic [DataWidth-1:0]         device_d_data,
  input  logic                         device_d_corrupt,

  output logic                         host_d_valid,
  input  logic                         host_d_ready,
  output logic [2:0]                   host_d_opcode,
  output logic [1:0]                   host_d_param,
  output logic [SizeWidth-1:0]         host_d_size,
  output logic [HostSourceWidth-1:0]   host_d_source,
  output logic [SinkWidth-1:0]         host_d_sink,
  output logic                         host_d_denied,
  output logic [DataWidth-1:0]         host_d_data,
  output logic                         host_d_corrupt,

  input  logic                         host_e_valid,
  output logic                         host_e_ready,
  output logic                         device_e_valid,
  input  logic                         device_e_ready
);

  localparam int N       = 2 ** DeviceSourceWidth;
  localparam int BeatLog = $clog2(DataWidth / 8);
  localparam int CntW    = (MaxSize > BeatLog) ? (MaxSize - BeatLog) : 1;

  // Remaining beats after the first one; zero for single-beat sizes.
  function automatic logic [CntW-1:0] beats_m1(input logic [SizeWidth-1:0] size);
    logic [31:0] b;
    b = 32'd0;
    if (int'(size) > BeatLog) b = (32'd1 << (int'(size) - BeatLog)) - 32'd1;
    return b[CntW-1:0];
  endfunction

  logic [N-1:0]                 inflight, inflight_next;
  logic [HostSourceWidth-1:0]   host_src [N];
  logic                         a_locked;
  logic [DeviceSourceWidth-1:0] lock_idx;
  logic [CntW-1:0]              a_cnt, d_cnt;

  logic                         any_free;
  logic [DeviceSourceWidth-1:0] free_idx;
  logic                         a_allow, a_fire, a_multi;
  logic [CntW-1:0]              a_len, d_len;
  logic                         d_fire, d_first, d_last;
  logic                         unused_inputs;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!inflight[i]) begin
        any_free = 1'b1;
        free_idx = DeviceSourceWidth'(i);
      end
    end
  end

  assign a_allow = a_locked || any_free;
  assign a_len   = beats_m1(host_a_size);
  assign a_multi = (host_a_opcode <= 3'd3) && (a_len != '0);

  assign device_a_valid   = host_a_valid && a_allow;
  assign host_a_ready     = device_a_ready && a_allow;
  assign a_fire           = host_a_valid && host_a_ready;
  assign device_a_source  = a_locked ? lock_idx : free_idx;
  assign device_a_opcode  = host_a_opcode;
  assign device_a_param   = host_a_param;
  assign device_a_size    = host_a_size;
  assign device_a_address = host_a_address;
  assign device_a_mask    = host_a_mask;
  assign device_a_data    = host_a_data;
  assign device_a_corrupt = host_a_corrupt;

  assign host_d_valid   = device_d_valid;
  assign device_d_ready = host_d_ready;
  assign host_d_source  = host_src[device_d_source];
  assign host_d_opcode  = device_d_opcode;
  assign host_d_param   = device_d_param;
  assign host_d_size    = device_d_size;
  assign host_d_sink    = device_d_sink;
  assign host_d_denied  = device_d_denied;
  assign host_d_data    = device_d_data;
  assign host_d_corrupt = device_d_corrupt;

  assign d_fire  = device_d_valid && host_d_ready;
  assign d_len   = (device_d_opcode == 3'd1) ? beats_m1(device_d_size) : '0;
  assign d_first = (d_cnt == '0);
  assign d_last  = d_first ? (d_len == '0) : (d_cnt == CntW'(1));

  assign host_b_valid   = 1'b0;
  assign device_b_ready = 1'b1;
  assign device_c_valid = 1'b0;
  assign host_c_ready   = 1'b0;
  assign device_e_valid = 1'b0;
  assign host_e_ready   = 1'b0;
  assign unused_inputs  = ^{host_b_ready, device_b_valid, host_c_valid,
                            device_c_ready, host_e_valid, device_e_ready};

  // Free is applied after allocate so it wins on a (protocol-illegal) clash.
  always_comb begin
    inflight_next = inflight;
    if (a_fire && !a_locked) inflight_next[free_idx] = 1'b1;
    if (d_fire && d_last) inflight_next[device_d_source] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
      a_locked <= 1'b0;
      lock_idx <= '0;
      a_cnt    <= '0;
      d_cnt    <= '0;
      for (int i = 0; i < N; i++) host_src[i] <= '0;
    end else begin
      inflight <= inflight_next;
      if (a_fire) begin
        if (a_locked) begin
          a_cnt <= a_cnt - CntW'(1);
          if (a_cnt == CntW'(1)) a_locked <= 1'b0;
        end else begin
          host_src[free_idx] <= host_a_source;
          if (a_multi) begin
            a_locked <= 1'b1;
            lock_idx <= free_idx;
            a_cnt    <= a_len;
          end
        end
      end
      if (d_fire) d_cnt <= d_first ? d_len : d_cnt - CntW'(1);
    end
  end

`ifndef SYNTHESIS
  a_d_same_index: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(a_fire && !a_locked && d_fire && d_last && (free_idx == device_d_source)));
  d_source_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    device_d_valid |-> inflight[device_d_source]);
  a_opcode_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    host_a_valid |-> (host_a_opcode < 3'd5));
  a_size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    host_a_valid |-> (int'(host_a_size) <= MaxSize));
  a_stable_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (host_a_valid && !host_a_ready) |=> $stable({host_a_opcode, host_a_param, host_a_size,
      host_a_source, host_a_address, host_a_mask, host_a_data, host_a_corrupt}));
`endif

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Directed bench for tl_source_shrinker: allocation, stall, bursts, D mapping, reset.
module tb_tl_source_shrinker;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         host_a_valid, host_a_ready;
  logic [2:0]   host_a_opcode, host_a_param;
  logic [2:0]   host_a_size;
  logic [7:0]   host_a_source;
  logic [55:0]  host_a_address;
  logic [7:0]   host_a_mask;
  logic [63:0]  host_a_data;
  logic         host_a_corrupt;
  logic         device_a_valid, device_a_ready;
  logic [2:0]   device_a_opcode, device_a_param;
  logic [2:0]   device_a_size;
  logic [1:0]   device_a_source;
  logic [55:0]  device_a_address;
  logic [7:0]   device_a_mask;
  logic [63:0]  device_a_data;
  logic         device_a_corrupt;
  logic         host_b_valid, host_b_ready, device_b_valid, device_b_ready;
  logic         host_c_valid, host_c_ready, device_c_valid, device_c_ready;
  logic         device_d_valid, device_d_ready;
  logic [2:0]   device_d_opcode;
  logic [1:0]   device_d_param;
  logic [2:0]   device_d_size;
  logic [1:0]   device_d_source;
  logic [0:0]   device_d_sink;
  logic         device_d_denied;
  logic [63:0]  device_d_data;
  logic         device_d_corrupt;
  logic         host_d_valid, host_d_ready;
  logic [2:0]   host_d_opcode;
  logic [1:0]   host_d_param;
  logic [2:0]   host_d_size;
  logic [7:0]   host_d_source;
  logic [0:0]   host_d_sink;
  logic         host_d_denied;
  logic [63:0]  host_d_data;
  logic         host_d_corrupt;
  logic         host_e_valid, host_e_ready, device_e_valid, device_e_ready;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  tl_source_shrinker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
    .host_a_opcode(host_a_opcode), .host_a_param(host_a_param),
    .host_a_size(host_a_size), .host_a_source(host_a_source),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask),
    .host_a_data(host_a_data), .host_a_corrupt(host_a_corrupt),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready),
    .device_a_opcode(device_a_opcode), .device_a_param(device_a_param),
    .device_a_size(device_a_size), .device_a_source(device_a_source),
    .device_a_address(device_a_address), .device_a_mask(device_a_mask),
    .device_a_data(device_a_data), .device_a_corrupt(device_a_corrupt),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready),
    .device_b_valid(device_b_valid), .device_b_ready(device_b_ready),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready),
    .device_c_valid(device_c_valid), .device_c_ready(device_c_ready),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready),
    .device_d_opcode(device_d_opcode), .device_d_param(device_d_param),
    .device_d_size(device_d_size), .device_d_source(device_d_source),
    .device_d_sink(device_d_sink), .device_d_denied(device_d_denied),
    .device_d_data(device_d_data), .device_d_corrupt(device_d_corrupt),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
    .host_d_opcode(host_d_opcode), .host_d_param(host_d_param),
    .host_d_size(host_d_size), .host_d_source(host_d_source),
    .host_d_sink(host_d_sink), .host_d_denied(host_d_denied),
    .host_d_data(host_d_data), .host_d_corrupt(host_d_corrupt),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready),
    .device_e_valid(device_e_valid), .device_e_ready(device_e_ready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one A beat at negedge, check the combinational mapping, then take the edge.
  task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                        input logic [1:0] exp_idx, input string tag);
    @(negedge clk_i);
    host_a_valid   = 1'b1;
    host_a_opcode  = op;
    host_a_size    = sz;
    host_a_source  = src;
    host_a_address = {48'h12_3456_789A, src};
    host_a_data    = {56'hA0A0_0000_0000_00, src};
    #1;
    chk({tag, "_valid"}, device_a_valid, 1'b1);
    chk({tag, "_ready"}, host_a_ready, 1'b1);
    chk({tag, "_src"}, device_a_source, exp_idx);
    chk({tag, "_pass"}, {device_a_address, device_a_data},
        {48'h12_3456_789A, src, 56'hA0A0_0000_0000_00, src});
    @(posedge clk_i);
  endtask

  task automatic a_idle();
    @(negedge clk_i);
    host_a_valid = 1'b0;
  endtask

  task automatic d_send(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [7:0] exp_host, input string tag);
    @(negedge clk_i);
    device_d_valid  = 1'b1;
    device_d_opcode = op;
    device_d_size   = sz;
    device_d_source = src;
    device_d_data   = {62'h3D0D_0000_0000_0000, src};
    #1;
    chk({tag, "_valid"}, host_d_valid, 1'b1);
    chk({tag, "_src"}, host_d_source, exp_host);
    chk({tag, "_data"}, host_d_data, {62'h3D0D_0000_0000_0000, src});
    @(posedge clk_i);
  endtask

  task automatic d_idle();
    @(negedge clk_i);
    device_d_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] gap_pattern;
    rst_ni = 1'b0;
    host_a_valid = 1'b0; host_a_opcode = 3'd4; host_a_param = 3'd0; host_a_size = 3'd3;
    host_a_source = 8'h00; host_a_address = '0; host_a_mask = 8'hFF; host_a_data = '0;
    host_a_corrupt = 1'b0; device_a_ready = 1'b1;
    host_b_ready = 1'b1; device_b_valid = 1'b1; host_c_valid = 1'b1; device_c_ready = 1'b1;
    host_e_valid = 1'b1; device_e_ready = 1'b1;
    device_d_valid = 1'b0; device_d_opcode = 3'd0; device_d_param = 2'd0; device_d_size = 3'd3;
    device_d_source = 2'd0; device_d_sink = 1'b0; device_d_denied = 1'b0; device_d_data = '0;
    device_d_corrupt = 1'b0; host_d_ready = 1'b1;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_a_valid", device_a_valid, 1'b0);
    chk("rst_d_valid", host_d_valid, 1'b0);
    chk("rst_unused", {host_b_valid, device_b_ready, device_c_valid, host_c_ready,
                       device_e_valid, host_e_ready}, 6'b010000);
    rst_ni = 1'b1;

    // Single Get round trip
    a_send(3'd4, 3'd3, 8'hA5, 2'd0, "t1_get");
    a_idle();
    d_send(3'd1, 3'd3, 2'd0, 8'hA5, "t1_ackdata");
    d_idle();

    // Fill the table, fifth Get stalls until a D completes; freed index usable next cycle
    a_send(3'd4, 3'd3, 8'h10, 2'd0, "t2_get0");
    a_send(3'd4, 3'd3, 8'h11, 2'd1, "t2_get1");
    a_send(3'd4, 3'd3, 8'h12, 2'd2, "t2_get2");
    a_send(3'd4, 3'd3, 8'h13, 2'd3, "t2_get3");
    @(negedge clk_i);
    host_a_source  = 8'h20;
    host_a_address = {48'h12_3456_789A, 8'h20};
    host_a_data    = {56'hA0A0_0000_0000_00, 8'h20};
    #1;
    chk("t2_full_ready", host_a_ready, 1'b0);
    chk("t2_full_valid", device_a_valid, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    device_d_valid = 1'b1; device_d_opcode = 3'd0; device_d_size = 3'd3; device_d_source = 2'd2;
    #1;
    chk("t5_coincide_ready", host_a_ready, 1'b0);
    chk("t5_coincide_dsrc", host_d_source, 8'h12);
    @(posedge clk_i);
    @(negedge clk_i);
    device_d_valid = 1'b0;
    #1;
    chk("t5_next_valid", device_a_valid, 1'b1);
    chk("t5_next_ready", host_a_ready, 1'b1);
    chk("t5_next_src", device_a_source, 2'd2);
    @(posedge clk_i);
    a_idle();
    d_send(3'd0, 3'd3, 2'd0, 8'h10, "t2_drain0");
    d_send(3'd0, 3'd3, 2'd1, 8'h11, "t2_drain1");
    d_send(3'd0, 3'd3, 2'd3, 8'h13, "t2_drain3");
    d_send(3'd0, 3'd3, 2'd2, 8'h20, "t2_drain2");
    d_idle();

    // 8-beat PutFullData keeps one device source and allocates once
    for (int b = 0; b < 8; b++) a_send(3'd0, 3'd6, 8'h77, 2'd0, "t3_put");
    a_send(3'd4, 3'd5, 8'h55, 2'd1, "t3_get55");
    a_send(3'd4, 3'd3, 8'h60, 2'd2, "t3_get60");
    a_send(3'd4, 3'd3, 8'h61, 2'd3, "t3_get61");
    a_idle();
    d_send(3'd0, 3'd6, 2'd0, 8'h77, "t3_ack");
    d_idle();
    a_send(3'd4, 3'd3, 8'h62, 2'd0, "t3_realloc");

    // 4-beat AccessAckData with gaps; entry 1 stays busy until the fourth beat
    @(negedge clk_i);
    host_a_source  = 8'h63;
    host_a_address = {48'h12_3456_789A, 8'h63};
    host_a_data    = {56'hA0A0_0000_0000_00, 8'h63};
    gap_pattern = 6'b101101;
    for (int s = 5; s >= 0; s--) begin
      if (s != 5) @(negedge clk_i);
      device_d_valid  = gap_pattern[s];
      device_d_opcode = 3'd1;
      device_d_size   = 3'd5;
      device_d_source = 2'd1;
      #1;
      chk("t4_held_ready", host_a_ready, 1'b0);
      if (gap_pattern[s]) chk("t4_beat_src", host_d_source, 8'h55);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    device_d_valid = 1'b0;
    #1;
    chk("t4_freed_ready", host_a_ready, 1'b1);
    chk("t4_freed_src", device_a_source, 2'd1);
    @(posedge clk_i);
    a_idle();

    // Reset mid-burst: Get on 0, Put on 1 at beat 3 of 8
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    a_send(3'd4, 3'd3, 8'h30, 2'd0, "t6_get");
    a_send(3'd0, 3'd6, 8'h31, 2'd1, "t6_put_b1");
    a_send(3'd0, 3'd6, 8'h31, 2'd1, "t6_put_b2");
    @(negedge clk_i);
    #1;
    chk("t6_put_b3_src", device_a_source, 2'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t6_lock_clear_src", device_a_source, 2'd0);
    host_a_valid = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    a_send(3'd4, 3'd3, 8'h40, 2'd0, "t6_after0");
    a_send(3'd4, 3'd3, 8'h41, 2'd1, "t6_after1");
    a_idle();
    d_send(3'd1, 3'd3, 2'd0, 8'h40, "t6_d0");
    d_send(3'd1, 3'd3, 2'd1, 8'h41, "t6_d1");
    d_idle();
    a_send(3'd4, 3'd3, 8'h42, 2'd0, "t6_reuse");
    a_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
